guess_solver: RTL and testbench
===============================

# guess_solver

Automated player for the number-guessing game. It drives `o_guess`/`o_enter` into the game block and reads back the registered over/under/equal indicators. From that feedback it runs a binary search until it hits the secret, runs out of tries, or sees an illegal response. It sits beside the game top-level, in place of the switches and button, for self-test and demo builds.

## Interface
Parameters:
- `WIDTH`, 8: guess/secret width.
- `MAX_TRIES`, 7: guesses allowed before giving up (1..15).
- `RESP_WAIT`, 2: cycles between the `o_enter` pulse and sampling the indicators (≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `i_start`  in  1  begin a search (level, sampled in IDLE/FOUND/FAIL/ERR).
- `i_over`  in  1  game indicator: guess > secret.
- `i_under`  in  1  game indicator: guess < secret.
- `i_equal`  in  1  game indicator: guess == secret.
- `o_guess`  out  WIDTH  current guess; registered.
- `o_enter`  out  1  one-cycle guess-submit pulse.
- `o_busy`  out  1  search in progress.
- `o_found`  out  1  secret found; `o_result` valid.
- `o_fail`  out  1  tries exhausted without a match.
- `o_err`  out  1  illegal or inconsistent response.
- `o_result`  out  WIDTH  matched value.
- `o_tries_used`  out  4  guesses submitted this search.

## Operation
- Reset: all outputs 0. State IDLE, lo=0, hi=2^WIDTH−1.
- States:
  - IDLE: on `i_start`, load lo=0, hi=max, tries=0 and compute the guess, then go to DRIVE.
  - DRIVE: `o_enter`=1, tries+=1, go to WAIT. This is the only state asserting `o_enter`, so it is low for at least RESP_WAIT+1 cycles between pulses.
  - WAIT: counts RESP_WAIT cycles, then goes to EVAL.
  - EVAL: samples the indicators, then:
    - Go to ERR if not exactly one indicator is high.
    - Equal: set `o_result`=guess and go to FOUND.
    - Over: if guess==0, go to ERR; else hi=guess−1.
    - Under: if guess==max, go to ERR; else lo=guess+1.
    - After the update: if lo>hi, go to ERR. Else if tries==MAX_TRIES, go to FAIL. Else compute the new guess and go to DRIVE.
  - FOUND/FAIL/ERR: terminal. Flags hold. `i_start` restarts the search exactly as from IDLE. Restarting the game itself is external.
- Arithmetic:
  - Midpoint is guess=(lo+hi)>>1, computed at WIDTH+1 bits (floor).
  - lo/hi update at WIDTH+1 bits so guess±1 never wraps.
- The equal check has priority over the tries check, so a match on the last allowed try reports FOUND.
- `o_busy`=1 in DRIVE/WAIT/EVAL.
- `o_found`, `o_fail` and `o_err` are mutually exclusive and clear on restart.
- Reset mid-search: immediate return to IDLE with all outputs 0. Any pending `o_enter` is dropped.

## Timing
- `i_start` high at cycle n (in IDLE): DRIVE at n+1, with `o_guess`=2^(WIDTH−1)−1 and `o_enter`=1.
- Per guess: DRIVE at t, WAIT t+1..t+RESP_WAIT, EVAL at t+RESP_WAIT+1, next DRIVE or terminal state at t+RESP_WAIT+2. That is 4 cycles per guess at the default.
- `o_guess` changes only on the EVAL→DRIVE edge. It is stable from the `o_enter` cycle through EVAL.
- Indicators are required valid from t+2 onward (game registers its LEDs one cycle after accepting enter). The default RESP_WAIT gives one cycle of margin.
- Terminal flags and `o_result` assert the cycle after EVAL.
- Worst-case search for WIDTH=8 is 9 guesses (secret 255). With MAX_TRIES=7, some secrets end in FAIL by design.

## Structure
- Shared package `game_pkg`: the state enum (S_IDLE, S_DRIVE, S_WAIT, S_EVAL, S_FOUND, S_FAIL, S_ERR) and the `GAME_WIDTH`=8 constant, shared with the game datapath.
- One sub-module, `solver_bounds`, is natural. It holds the lo/hi registers, the midpoint, the lo>hi/edge error detection, and load/update strobes from the FSM. The top level holds the FSM, wait counter and tries counter.

## Test plan
- Bench contains a behavioral responder with secret S that registers indicators one cycle after `o_enter`.
- S=127, defaults → one `o_enter`, `o_guess`=127, `o_found`=1, `o_result`=127, `o_tries_used`=1, flag asserted 5 cycles after `i_start`.
- S=100, MAX_TRIES=8 → guesses 127,63,95,111,103,99,101,100; `o_found`, `o_tries_used`=8. With MAX_TRIES=7 → `o_fail` after the guess 101, tries=7, `o_found`=0.
- S=255, MAX_TRIES=9 → guesses 127,191,223,239,247,251,253,254,255; found, no wrap.
- Responder drives all indicators low, or over+equal together → `o_err` at first EVAL, `o_enter` never pulses again. Responder reports over at guess 0 → `o_err`.
- Reset asserted in WAIT → all outputs 0 same cycle. Then `i_start` with S=0 → search restarts from 127, found at 0 with tries=8 (MAX_TRIES=8).
- Check `o_enter` pulse width is exactly 1 and its gap is ≥RESP_WAIT+1 across all scenarios. Check `o_guess` stability between pulse and EVAL.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the number-guessing game and its
//                automated solver: datapath width and solver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Width of guesses and secrets in the game datapath
  localparam int GAME_WIDTH = 8;

  // Solver control states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_FOUND = 3'd4,
    S_FAIL  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/solver_bounds.sv
`default_nettype none
// ============================================================================
//  Module      : solver_bounds
//  Description : Binary-search interval for the guess solver. Holds lo/hi at
//                WIDTH+1 bits, produces the midpoint for the next guess and
//                flags responses that would leave the value range or empty
//                the interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module solver_bounds #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,       // start of search: reset interval to full range
  input  logic             update,     // accept the candidate interval after a response
  input  logic             step_down,  // response says guess is above the secret
  input  logic             step_up,    // response says guess is below the secret
  input  logic [WIDTH-1:0] guess,      // guess the response refers to
  output logic [WIDTH-1:0] next_mid,   // guess to submit next
  output logic             edge_err,   // step beyond 0 or max requested
  output logic             order_err   // candidate interval is empty
);

  localparam logic [WIDTH:0] FULL_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] lo;
  logic [WIDTH:0] hi;
  logic [WIDTH:0] guess_x;
  logic [WIDTH:0] lo_c;
  logic [WIDTH:0] hi_c;
  logic [WIDTH:0] base_lo;
  logic [WIDTH:0] base_hi;

  assign guess_x = {1'b0, guess};

  // Candidate interval if the current response is accepted; one extra bit
  // keeps guess+1 at the top of the range from wrapping to zero.
  always_comb begin
    lo_c = lo;
    hi_c = hi;
    if (step_down) begin
      hi_c = guess_x - ONE;
    end
    if (step_up) begin
      lo_c = guess_x + ONE;
    end
  end

  // Guess 0 cannot be too high and guess max cannot be too low; either
  // claim means the responder is inconsistent.
  assign edge_err  = (step_down && (guess == '0)) || (step_up && (guess == '1));
  assign order_err = (lo_c > hi_c);

  // Midpoint of the interval that will be live for the next guess (floor).
  assign base_lo  = load ? '0 : lo_c;
  assign base_hi  = load ? FULL_MAX : hi_c;
  assign next_mid = WIDTH'((base_lo + base_hi) >> 1);

  // Interval registers: reload on a new search, narrow on an accepted response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo <= '0;
      hi <= FULL_MAX;
    end else if (load) begin
      lo <= '0;
      hi <= FULL_MAX;
    end else if (update) begin
      lo <= lo_c;
      hi <= hi_c;
    end
  end

endmodule : solver_bounds
`default_nettype wire

// File: rtl/guess_solver.sv
`default_nettype none
// ============================================================================
//  Module      : guess_solver
//  Description : Automated player for the number-guessing game. Submits
//                guesses with a one-cycle enter pulse, waits for the game's
//                registered over/under/equal indicators and binary-searches
//                until it hits the secret, runs out of tries, or sees an
//                illegal response.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_solver
  import game_pkg::*;
#(
  parameter int WIDTH     = GAME_WIDTH,
  parameter int MAX_TRIES = 7,
  parameter int RESP_WAIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_over,
  input  logic             i_under,
  input  logic             i_equal,
  output logic [WIDTH-1:0] o_guess,
  output logic             o_enter,
  output logic             o_busy,
  output logic             o_found,
  output logic             o_fail,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_tries_used
);

  localparam int                WAIT_W      = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(RESP_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_STEP   = WAIT_W'(1);
  localparam logic [3:0]        TRIES_LIMIT = 4'(MAX_TRIES);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WIDTH-1:0]  next_guess;
  logic              start_ok;
  logic              resp_onehot;
  logic              hit;
  logic              edge_err;
  logic              order_err;
  logic              update_bounds;

  // A new search may begin from idle or any terminal state.
  assign start_ok = i_start && ((state == S_IDLE) || (state == S_FOUND) ||
                                (state == S_FAIL) || (state == S_ERR));

  // Exactly one indicator must be high for a response to be meaningful.
  assign resp_onehot = ({i_over, i_under, i_equal} == 3'b100) ||
                       ({i_over, i_under, i_equal} == 3'b010) ||
                       ({i_over, i_under, i_equal} == 3'b001);

  assign hit           = (state == S_EVAL) && resp_onehot && i_equal;
  assign update_bounds = (state == S_EVAL) && (next_state == S_DRIVE);

  solver_bounds #(
    .WIDTH (WIDTH)
  ) u_bounds (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok),
    .update    (update_bounds),
    .step_down (i_over),
    .step_up   (i_under),
    .guess     (o_guess),
    .next_mid  (next_guess),
    .edge_err  (edge_err),
    .order_err (order_err)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; in EVAL a match outranks the tries limit so a hit on
  // the last allowed guess still reports found.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_FOUND, S_FAIL, S_ERR: begin
        if (i_start) begin
          next_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!resp_onehot) begin
          next_state = S_ERR;
        end else if (i_equal) begin
          next_state = S_FOUND;
        end else if (edge_err || order_err) begin
          next_state = S_ERR;
        end else if (o_tries_used == TRIES_LIMIT) begin
          next_state = S_FAIL;
        end else begin
          next_state = S_DRIVE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Guess, tries, wait counter and result registers; the guess only moves
  // when a new DRIVE is entered so it is stable through WAIT and EVAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_guess      <= '0;
      o_tries_used <= '0;
      o_result     <= '0;
      wait_cnt     <= '0;
    end else begin
      if (start_ok) begin
        o_guess      <= next_guess;
        o_tries_used <= '0;
        o_result     <= '0;
      end else if (update_bounds) begin
        o_guess <= next_guess;
      end

      if (state == S_DRIVE) begin
        o_tries_used <= o_tries_used + 4'd1;
        wait_cnt     <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_STEP;
      end

      if (hit) begin
        o_result <= o_guess;
      end
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    o_enter = 1'b0;
    o_busy  = 1'b0;
    o_found = 1'b0;
    o_fail  = 1'b0;
    o_err   = 1'b0;
    case (state)
      S_DRIVE: begin
        o_enter = 1'b1;
        o_busy  = 1'b1;
      end
      S_WAIT:  o_busy  = 1'b1;
      S_EVAL:  o_busy  = 1'b1;
      S_FOUND: o_found = 1'b1;
      S_FAIL:  o_fail  = 1'b1;
      S_ERR:   o_err   = 1'b1;
      default: o_busy  = 1'b0;
    endcase
  end

endmodule : guess_solver
`default_nettype wire

// File: tb/tb_guess_solver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_solver
//  Description : Directed bench for guess_solver. Three solvers with
//                MAX_TRIES 7, 8 and 9 share start/reset and each answers a
//                behavioural game responder holding the same secret.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_solver;

  localparam int W  = 8;
  localparam int RW = 2;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       start  = 1'b0;
  logic       clr    = 1'b0;
  logic [7:0] secret = 8'd0;
  int         mode   = 0;   // 0 honest, 1 all low, 2 over+equal, 3 always over
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int MT = 7 + i;
    logic       over_r  = 1'b0;
    logic       under_r = 1'b0;
    logic       equal_r = 1'b0;
    logic [7:0] guess;
    logic [7:0] result;
    logic       enter, busy, found, fail, err;
    logic [3:0] tries;
    int         n_enter = 0;
    int         viol    = 0;
    int         low_run = 0;
    logic       prev_enter = 1'b0;
    logic       seen       = 1'b0;
    logic [7:0] held       = 8'd0;
    logic [7:0] glog [0:15];

    guess_solver #(.WIDTH(W), .MAX_TRIES(MT), .RESP_WAIT(RW)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (start),
      .i_over       (over_r),
      .i_under      (under_r),
      .i_equal      (equal_r),
      .o_guess      (guess),
      .o_enter      (enter),
      .o_busy       (busy),
      .o_found      (found),
      .o_fail       (fail),
      .o_err        (err),
      .o_result     (result),
      .o_tries_used (tries)
    );

    // Game responder: registers indicators one cycle after enter.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        over_r <= 1'b0; under_r <= 1'b0; equal_r <= 1'b0;
      end else if (enter) begin
        case (mode)
          1:       {over_r, under_r, equal_r} <= 3'b000;
          2:       {over_r, under_r, equal_r} <= 3'b101;
          3:       {over_r, under_r, equal_r} <= 3'b100;
          default: {over_r, under_r, equal_r} <= {guess > secret, guess < secret, guess == secret};
        endcase
      end
    end

    // Enter pulse width/gap and guess stability monitor, plus guess log.
    always @(negedge clk) begin
      if (!reset) begin
        viol <= viol + (((enter && prev_enter) ||
                         (enter && !prev_enter && seen && low_run < RW + 1) ||
                         (!enter && busy && guess !== held)) ? 1 : 0);
      end
      prev_enter <= enter;
      if (enter) begin
        held <= guess; seen <= 1'b1; low_run <= 0;
      end else begin
        low_run <= low_run + 1;
      end
      if (clr) begin
        n_enter <= 0;
      end else if (enter) begin
        if (n_enter < 16) glog[n_enter] <= guess;
        n_enter <= n_enter + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller one cycle after start was sampled (the DRIVE cycle).
  task automatic begin_search(input logic [7:0] s, input int m);
    secret = s; mode = m; clr = 1'b1;
    tick();
    clr = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((g_dut[0].busy || g_dut[1].busy || g_dut[2].busy) && n < budget) begin
      tick();
      n++;
    end
    compared++;
    if (g_dut[0].busy || g_dut[1].busy || g_dut[2].busy) begin
      mismatched++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    compared++;
    if ({g_dut[0].guess, g_dut[0].enter, g_dut[0].busy, g_dut[0].found, g_dut[0].fail,
         g_dut[0].err, g_dut[0].result, g_dut[0].tries} !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_async: outputs=%h required 0", {g_dut[0].guess, g_dut[0].result, g_dut[0].tries});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 1; k++) begin
      compared++;
      if ({g_dut[1].guess, g_dut[1].enter, g_dut[1].busy, g_dut[1].found, g_dut[1].fail,
           g_dut[1].err, g_dut[1].result, g_dut[1].tries} !== 25'd0) begin
        mismatched++;
        $display("FAIL reset_idle1: outputs nonzero, required 0");
      end
      compared++;
      if ({g_dut[2].guess, g_dut[2].enter, g_dut[2].busy, g_dut[2].found, g_dut[2].fail,
           g_dut[2].err, g_dut[2].result, g_dut[2].tries} !== 25'd0) begin
        mismatched++;
        $display("FAIL reset_idle2: outputs nonzero, required 0");
      end
    end
  endtask

  task automatic test_mid_hit();
    begin_search(8'd127, 0);
    compared++;
    if (g_dut[0].enter !== 1'b1 || g_dut[0].guess !== 8'd127) begin
      mismatched++;
      $display("FAIL first_drive: enter=%b guess=%0d required enter=1 guess=127", g_dut[0].enter, g_dut[0].guess);
    end
    tick(); tick(); tick();
    compared++;
    if (g_dut[0].busy !== 1'b1 || g_dut[0].found !== 1'b0) begin
      mismatched++;
      $display("FAIL eval_cycle: busy=%b found=%b required busy=1 found=0", g_dut[0].busy, g_dut[0].found);
    end
    tick();
    compared++;
    if (g_dut[0].found !== 1'b1 || g_dut[0].result !== 8'd127 || g_dut[0].tries !== 4'd1 || g_dut[0].busy !== 1'b0) begin
      mismatched++;
      $display("FAIL hit127: found=%b result=%0d tries=%0d required found=1 result=127 tries=1",
               g_dut[0].found, g_dut[0].result, g_dut[0].tries);
    end
    tick(); tick(); tick(); tick();
    compared++;
    if (g_dut[0].n_enter !== 1 || g_dut[0].found !== 1'b1) begin
      mismatched++;
      $display("FAIL hit127_hold: enters=%0d found=%b required enters=1 found=1", g_dut[0].n_enter, g_dut[0].found);
    end
  endtask

  task automatic test_s100();
    logic [7:0] exp_seq [0:7];
    exp_seq = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100};
    begin_search(8'd100, 0);
    wait_idle(100);
    for (int j = 0; j < 8; j++) begin
      compared++;
      if (g_dut[1].glog[j] !== exp_seq[j]) begin
        mismatched++;
        $display("FAIL s100_seq[%0d]: guess=%0d required %0d", j, g_dut[1].glog[j], exp_seq[j]);
      end
    end
    compared++;
    if (g_dut[1].found !== 1'b1 || g_dut[1].result !== 8'd100 || g_dut[1].tries !== 4'd8) begin
      mismatched++;
      $display("FAIL s100_mt8: found=%b result=%0d tries=%0d required 1/100/8", g_dut[1].found, g_dut[1].result, g_dut[1].tries);
    end
    compared++;
    if (g_dut[0].fail !== 1'b1 || g_dut[0].found !== 1'b0 || g_dut[0].tries !== 4'd7 ||
        g_dut[0].n_enter !== 7 || g_dut[0].glog[6] !== 8'd101) begin
      mismatched++;
      $display("FAIL s100_mt7: fail=%b found=%b tries=%0d enters=%0d last=%0d required 1/0/7/7/101",
               g_dut[0].fail, g_dut[0].found, g_dut[0].tries, g_dut[0].n_enter, g_dut[0].glog[6]);
    end
  endtask

  task automatic test_s255();
    logic [7:0] exp_seq [0:8];
    exp_seq = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    begin_search(8'd255, 0);
    wait_idle(100);
    for (int j = 0; j < 9; j++) begin
      compared++;
      if (g_dut[2].glog[j] !== exp_seq[j]) begin
        mismatched++;
        $display("FAIL s255_seq[%0d]: guess=%0d required %0d", j, g_dut[2].glog[j], exp_seq[j]);
      end
    end
    compared++;
    if (g_dut[2].found !== 1'b1 || g_dut[2].result !== 8'd255 || g_dut[2].tries !== 4'd9 || g_dut[2].err !== 1'b0) begin
      mismatched++;
      $display("FAIL s255_mt9: found=%b result=%0d tries=%0d err=%b required 1/255/9/0",
               g_dut[2].found, g_dut[2].result, g_dut[2].tries, g_dut[2].err);
    end
    compared++;
    if (g_dut[1].fail !== 1'b1 || g_dut[1].tries !== 4'd8) begin
      mismatched++;
      $display("FAIL s255_mt8: fail=%b tries=%0d required 1/8", g_dut[1].fail, g_dut[1].tries);
    end
  endtask

  task automatic test_err_none();
    begin_search(8'd55, 1);
    compared++;
    if (g_dut[2].found !== 1'b0 || g_dut[2].result !== 8'd0 || g_dut[2].busy !== 1'b1 ||
        g_dut[0].fail !== 1'b0 || g_dut[0].err !== 1'b0) begin
      mismatched++;
      $display("FAIL restart_clear: found2=%b result2=%0d busy2=%b fail0=%b required 0/0/1/0",
               g_dut[2].found, g_dut[2].result, g_dut[2].busy, g_dut[0].fail);
    end
    tick(); tick(); tick(); tick();
    compared++;
    if (g_dut[1].err !== 1'b1 || g_dut[1].found !== 1'b0 || g_dut[1].fail !== 1'b0) begin
      mismatched++;
      $display("FAIL none_high: err=%b found=%b fail=%b required 1/0/0", g_dut[1].err, g_dut[1].found, g_dut[1].fail);
    end
    tick(); tick(); tick(); tick(); tick(); tick();
    compared++;
    if (g_dut[1].n_enter !== 1 || g_dut[1].err !== 1'b1) begin
      mismatched++;
      $display("FAIL none_high_hold: enters=%0d err=%b required 1/1", g_dut[1].n_enter, g_dut[1].err);
    end
  endtask

  task automatic test_err_multi();
    begin_search(8'd127, 2);
    wait_idle(100);
    tick(); tick(); tick(); tick();
    compared++;
    if (g_dut[0].err !== 1'b1 || g_dut[0].found !== 1'b0 || g_dut[0].n_enter !== 1) begin
      mismatched++;
      $display("FAIL over_equal: err=%b found=%b enters=%0d required 1/0/1",
               g_dut[0].err, g_dut[0].found, g_dut[0].n_enter);
    end
  endtask

  task automatic test_err_edge();
    begin_search(8'd0, 3);
    wait_idle(100);
    compared++;
    if (g_dut[1].err !== 1'b1 || g_dut[1].tries !== 4'd8 || g_dut[1].glog[7] !== 8'd0 || g_dut[1].n_enter !== 8) begin
      mismatched++;
      $display("FAIL over_at_zero: err=%b tries=%0d last=%0d enters=%0d required 1/8/0/8",
               g_dut[1].err, g_dut[1].tries, g_dut[1].glog[7], g_dut[1].n_enter);
    end
    compared++;
    if (g_dut[0].fail !== 1'b1 || g_dut[0].err !== 1'b0 || g_dut[0].tries !== 4'd7) begin
      mismatched++;
      $display("FAIL over_mt7: fail=%b err=%b tries=%0d required 1/0/7", g_dut[0].fail, g_dut[0].err, g_dut[0].tries);
    end
  endtask

  task automatic test_reset_mid();
    begin_search(8'd0, 0);
    tick();
    #1 reset = 1'b1;
    #1;
    compared++;
    if ({g_dut[1].guess, g_dut[1].enter, g_dut[1].busy, g_dut[1].found, g_dut[1].fail,
         g_dut[1].err, g_dut[1].result, g_dut[1].tries} !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_wait: guess=%0d busy=%b tries=%0d required all 0",
               g_dut[1].guess, g_dut[1].busy, g_dut[1].tries);
    end
    tick();
    reset = 1'b0;
    tick();
    begin_search(8'd0, 0);
    compared++;
    if (g_dut[1].guess !== 8'd127 || g_dut[1].enter !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_127: guess=%0d enter=%b required 127/1", g_dut[1].guess, g_dut[1].enter);
    end
    wait_idle(100);
    compared++;
    if (g_dut[1].found !== 1'b1 || g_dut[1].result !== 8'd0 || g_dut[1].tries !== 4'd8) begin
      mismatched++;
      $display("FAIL s0_mt8: found=%b result=%0d tries=%0d required 1/0/8", g_dut[1].found, g_dut[1].result, g_dut[1].tries);
    end
  endtask

  task automatic test_protocol();
    compared++;
    if (g_dut[0].viol !== 0) begin
      mismatched++;
      $display("FAIL protocol0: violations=%0d required 0", g_dut[0].viol);
    end
    compared++;
    if (g_dut[1].viol !== 0) begin
      mismatched++;
      $display("FAIL protocol1: violations=%0d required 0", g_dut[1].viol);
    end
    compared++;
    if (g_dut[2].viol !== 0) begin
      mismatched++;
      $display("FAIL protocol2: violations=%0d required 0", g_dut[2].viol);
    end
  endtask

  initial begin
    test_reset();
    test_mid_hit();
    test_s100();
    test_s255();
    test_err_none();
    test_err_multi();
    test_err_edge();
    test_reset_mid();
    tick(); tick();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule : tb_guess_solver
`default_nettype wire
